pcard_unpack: RTL and testbench
===============================

# pcard_unpack

Receive-side counterpart of the packet-card packer. It takes the single packed 32-bit AXI-Stream arriving from the Aurora user interface and locks onto frame headers. It then de-interleaves the sample words into two independent AXI-Stream outputs (channel A, channel B), each buffered by its own FIFO. It sits between the Aurora RX user port and the per-channel ADC sample consumers, and reports framing and sequence errors plus a completed-frame count.

## Interface
Parameters:
- FIFO_DEPTH, 16, entries per output FIFO; power of two, ≥4.
- SYNC_WORD, 16'hA5C3, value of header bits [31:16].

Ports:
- axis_aclk  in  1  single clock for all logic.
- axis_aresetn  in  1  reset, asynchronous assert, active-low.
- s_axis_tdata  in  32  packed input word.
- s_axis_tvalid  in  1  input valid.
- s_axis_tready  out  1  input ready.
- m_axis_a_tdata  out  32  channel A sample.
- m_axis_a_tvalid  out  1  channel A valid.
- m_axis_a_tready  in  1  channel A ready.
- m_axis_a_tlast  out  1  last A sample of a frame.
- m_axis_b_tdata  out  32  channel B sample.
- m_axis_b_tvalid  out  1  channel B valid.
- m_axis_b_tready  in  1  channel B ready.
- m_axis_b_tlast  out  1  last B sample of a frame.
- hdr_err  out  1  one-cycle pulse on a framing error.
- seq_err  out  1  one-cycle pulse on a sequence discontinuity.
- frame_cnt  out  16  number of completed frames, wraps.

## Operation
- Frame format:
  - Header word: {SYNC_WORD[15:0], seq[7:0], len[7:0]}, where len is the number of sample pairs, 1..255.
  - The header is followed by 2·len sample words in strict order A, B, A, B, …
- A word is "valid header" when bits [31:16] == SYNC_WORD and len != 0.
- State machine states: HUNT, HDR, SAMP_A, SAMP_B.
  - HUNT: accepts and discards words until a valid header is seen. Then it latches seq, loads pairs_left = len, and goes to SAMP_A. Non-header words in HUNT raise no error.
  - HDR: entered after the final B word of a frame; the next accepted word must be a valid header.
    - Valid header: handled as in HUNT.
    - Otherwise: pulse hdr_err, discard the word, go to HUNT.
  - SAMP_A: the accepted word is pushed to FIFO A with tlast = (pairs_left == 1). Go to SAMP_B.
  - SAMP_B: the accepted word is pushed to FIFO B with the same tlast rule and pairs_left decrements.
    - If pairs_left was 1: increment frame_cnt (16'hFFFF wraps to 0) and go to HDR.
    - Otherwise: go to SAMP_A.
- Sequence check applies only to headers accepted after the first one since reset.
  - seq must equal prev_seq+1 mod 256 (8'hFF → 8'h00 is legal).
  - On mismatch, pulse seq_err in the same cycle; the frame is still accepted and prev_seq is updated.
  - A header accepted from HUNT after an hdr_err is also checked.
- A header word inside SAMP_A/SAMP_B is treated as data; no in-frame resync.
- s_axis_tready:
  - 1 in HUNT and HDR.
  - !full_a in SAMP_A.
  - !full_b in SAMP_B.
  - tready is never combinationally dependent on s_axis_tvalid.
- FIFOs: 33 bits wide {tlast, tdata}, show-ahead. m_axis_x_tvalid = !empty_x.
  - A pop occurs when tvalid && tready. Push and pop in the same cycle leave the count unchanged.
  - A push while full cannot occur, by construction of tready.
- Output channels are independent; a stalled B consumer stalls input only when FIFO B is full and the state is SAMP_B.

## Timing
- Reset (axis_aresetn low, asynchronous) clears the following; there is no partial-state retention:
  - state → HUNT.
  - FIFOs empty; m_axis_a/b_tvalid = 0, tlast = 0, tdata = 0.
  - s_axis_tready = 0 while in reset.
  - hdr_err = seq_err = 0.
  - frame_cnt = 0.
  - first-header flag set.
- Reset asserted mid-frame drops the partial frame and all buffered samples.
- First cycle after reset release: s_axis_tready = 1.
- Latency: a sample accepted at edge N has m_axis_x_tvalid high after edge N (visible in cycle N+1) if that FIFO was empty.
- hdr_err and seq_err are registered, high for exactly the cycle after the offending word is accepted.
- frame_cnt updates on the edge accepting the final B word.
- Full throughput: one input word per cycle when both consumers hold tready = 1; a header costs one input cycle.

## Structure
- Package pcard_pkg holds:
  - SYNC_WORD default.
  - Header field positions (SYNC [31:16], SEQ [15:8], LEN [7:0]).
  - State enum (HUNT, HDR, SAMP_A, SAMP_B).
- Sub-module pcard_sync_fifo (parameterised width/depth, show-ahead, full/empty, registered outputs) is instantiated twice.
- Top level contains only the FSM, counters and error logic.

## Test plan
- Reset, then header 32'hA5C3_0002 followed by A0,B0,A1,B1 with consumers always ready:
  - A outputs A0, A1 with tlast on A1; B outputs B0, B1 with tlast on B1.
  - frame_cnt = 1, no error pulses.
- Junk words 32'h1234_5678 ×3 before a header, then junk 32'hDEAD_BEEF in HDR:
  - No error during the initial hunt.
  - Exactly one hdr_err pulse after DEAD_BEEF.
  - A following valid header with len = 1 is decoded.
- Headers with seq 8'hFE, 8'hFF, 8'h00, 8'h02: a single seq_err pulse on seq 02; all four frames delivered; frame_cnt = 4.
- m_axis_b_tready held 0, frame with len = FIFO_DEPTH+2:
  - s_axis_tready drops in SAMP_B once FIFO B holds FIFO_DEPTH entries; no word lost or duplicated.
  - After release, all samples emerge in order.
- Assert axis_aresetn low mid-frame with both FIFOs non-empty:
  - All tvalid drop asynchronously; frame_cnt = 0.
  - After release, a fresh frame decodes with no seq_err.
- 256 back-to-back frames with len = 1 and random consumer ready: frame_cnt = 256, all samples match, zero error pulses.

Source files
------------

// File: rtl/pcard_pkg.sv
// Purpose: shared header layout, sync word and FSM states for the packet-card unpacker.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package pcard_pkg;

  localparam logic [15:0] SYNC_WORD_DEF = 16'hA5C3;

  // Header word layout: {sync[15:0], seq[7:0], len[7:0]}
  localparam int SYNC_MSB = 31;
  localparam int SYNC_LSB = 16;
  localparam int SEQ_MSB  = 15;
  localparam int SEQ_LSB  = 8;
  localparam int LEN_MSB  = 7;
  localparam int LEN_LSB  = 0;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    HDR    = 2'd1,
    SAMP_A = 2'd2,
    SAMP_B = 2'd3
  } state_t;

  // A header is only usable when the sync matches and it announces at least one pair.
  function automatic logic is_valid_hdr(input logic [31:0] w, input logic [15:0] sync);
    return (w[SYNC_MSB:SYNC_LSB] == sync) && (w[LEN_MSB:LEN_LSB] != 8'd0);
  endfunction

endpackage

// File: rtl/pcard_sync_fifo.sv
// Purpose: show-ahead synchronous FIFO with a registered head-of-queue output stage.
// Latency: a write into an empty FIFO is visible on rd_dat/!empty after the same edge.
// Backpressure: full asserts at DEPTH entries; the writer must hold off while full.
// Ports: clk/rst_n; wr_en/wr_dat/full on the write side; rd_en/rd_dat/empty on the read side.
module pcard_sync_fifo #(
  parameter int WIDTH = 33,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_dat,
  output logic             full,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_dat,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      mem_cnt;   // entries held in mem, excluding the output stage
  logic             out_vld;
  logic [WIDTH-1:0] out_dat;
  logic [AW:0]      occ;

  logic pop;
  logic load;
  logic from_mem;
  logic bypass;
  logic to_mem;

  always_comb begin
    pop      = out_vld & rd_en;
    load     = !out_vld | pop;
    from_mem = load && (mem_cnt != '0);
    // With mem empty, a fresh write goes straight into the output stage.
    bypass   = load && (mem_cnt == '0) && wr_en;
    to_mem   = wr_en && !bypass;
    occ      = mem_cnt + {{AW{1'b0}}, out_vld};
  end

  assign full   = (occ == (AW+1)'(DEPTH));
  assign empty  = !out_vld;
  assign rd_dat = out_dat;

  always_ff @(posedge clk) begin
    if (to_mem) begin
      mem[wr_ptr] <= wr_dat;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      mem_cnt <= '0;
      out_vld <= 1'b0;
      out_dat <= '0;
    end else begin
      if (to_mem) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (from_mem) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      mem_cnt <= mem_cnt + (AW+1)'(to_mem) - (AW+1)'(from_mem);
      if (from_mem) begin
        out_dat <= mem[rd_ptr];
        out_vld <= 1'b1;
      end else if (bypass) begin
        out_dat <= wr_dat;
        out_vld <= 1'b1;
      end else if (pop) begin
        out_vld <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/pcard_unpack.sv
// Purpose: lock onto packet-card headers and de-interleave A/B sample words into two FIFOs.
// Latency: a sample accepted at edge N is valid on its channel output after edge N.
// Backpressure: s_axis_tready drops only when the FIFO for the expected sample is full.
// Ports: s_axis_* packed input; m_axis_a_*/m_axis_b_* per-channel outputs with tlast;
//        hdr_err/seq_err one-cycle error pulses; frame_cnt completed-frame counter.
module pcard_unpack
  import pcard_pkg::*;
#(
  parameter int          FIFO_DEPTH = 16,
  parameter logic [15:0] SYNC_WORD  = SYNC_WORD_DEF
) (
  input  logic        axis_aclk,
  input  logic        axis_aresetn,
  input  logic [31:0] s_axis_tdata,
  input  logic        s_axis_tvalid,
  output logic        s_axis_tready,
  output logic [31:0] m_axis_a_tdata,
  output logic        m_axis_a_tvalid,
  input  logic        m_axis_a_tready,
  output logic        m_axis_a_tlast,
  output logic [31:0] m_axis_b_tdata,
  output logic        m_axis_b_tvalid,
  input  logic        m_axis_b_tready,
  output logic        m_axis_b_tlast,
  output logic        hdr_err,
  output logic        seq_err,
  output logic [15:0] frame_cnt
);

  state_t      state;
  logic [7:0]  pairs_left;
  logic [7:0]  prev_seq;
  logic        first_hdr;   // no predecessor to compare against yet

  logic        full_a;
  logic        full_b;
  logic        empty_a;
  logic        empty_b;
  logic [32:0] rd_a;
  logic [32:0] rd_b;

  logic        accept;
  logic        hdr_ok;
  logic        last_pair;
  logic        push_a;
  logic        push_b;
  logic [32:0] wr_word;
  logic [7:0]  hdr_seq;
  logic [7:0]  hdr_len;

  // Ready depends only on registered state and FIFO fill, never on tvalid.
  // It is held low while reset is asserted.
  always_comb begin
    s_axis_tready = 1'b0;
    case (state)
      HUNT, HDR: s_axis_tready = axis_aresetn;
      SAMP_A:    s_axis_tready = axis_aresetn & !full_a;
      SAMP_B:    s_axis_tready = axis_aresetn & !full_b;
      default:   s_axis_tready = 1'b0;
    endcase
  end

  always_comb begin
    accept    = s_axis_tvalid & s_axis_tready;
    hdr_ok    = is_valid_hdr(s_axis_tdata, SYNC_WORD);
    hdr_seq   = s_axis_tdata[SEQ_MSB:SEQ_LSB];
    hdr_len   = s_axis_tdata[LEN_MSB:LEN_LSB];
    last_pair = (pairs_left == 8'd1);
    push_a    = accept && (state == SAMP_A);
    push_b    = accept && (state == SAMP_B);
    wr_word   = {last_pair, s_axis_tdata};
  end

  always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
    if (!axis_aresetn) begin
      state      <= HUNT;
      pairs_left <= 8'd0;
      prev_seq   <= 8'd0;
      first_hdr  <= 1'b1;
      hdr_err    <= 1'b0;
      seq_err    <= 1'b0;
      frame_cnt  <= 16'd0;
    end else begin
      hdr_err <= 1'b0;
      seq_err <= 1'b0;
      if (accept) begin
        case (state)
          HUNT, HDR: begin
            if (hdr_ok) begin
              if (!first_hdr && (hdr_seq != 8'(prev_seq + 8'd1))) begin
                seq_err <= 1'b1;
              end
              prev_seq   <= hdr_seq;
              first_hdr  <= 1'b0;
              pairs_left <= hdr_len;
              state      <= SAMP_A;
            end else if (state == HDR) begin
              // Junk while in HUNT is silently skipped; junk where a header
              // was due is a framing error and drops us back to hunting.
              hdr_err <= 1'b1;
              state   <= HUNT;
            end
          end
          SAMP_A: begin
            state <= SAMP_B;
          end
          SAMP_B: begin
            pairs_left <= pairs_left - 8'd1;
            if (last_pair) begin
              frame_cnt <= frame_cnt + 16'd1;
              state     <= HDR;
            end else begin
              state <= SAMP_A;
            end
          end
          default: state <= HUNT;
        endcase
      end
    end
  end

  pcard_sync_fifo #(.WIDTH(33), .DEPTH(FIFO_DEPTH)) u_fifo_a (
    .clk    (axis_aclk),
    .rst_n  (axis_aresetn),
    .wr_en  (push_a),
    .wr_dat (wr_word),
    .full   (full_a),
    .rd_en  (m_axis_a_tready),
    .rd_dat (rd_a),
    .empty  (empty_a)
  );

  pcard_sync_fifo #(.WIDTH(33), .DEPTH(FIFO_DEPTH)) u_fifo_b (
    .clk    (axis_aclk),
    .rst_n  (axis_aresetn),
    .wr_en  (push_b),
    .wr_dat (wr_word),
    .full   (full_b),
    .rd_en  (m_axis_b_tready),
    .rd_dat (rd_b),
    .empty  (empty_b)
  );

  assign m_axis_a_tvalid = !empty_a;
  assign m_axis_a_tlast  = rd_a[32];
  assign m_axis_a_tdata  = rd_a[31:0];
  assign m_axis_b_tvalid = !empty_b;
  assign m_axis_b_tlast  = rd_b[32];
  assign m_axis_b_tdata  = rd_b[31:0];

endmodule

// File: tb/tb_pcard_unpack.sv
module tb_pcard_unpack;

  localparam int          DEPTH = 16;
  localparam logic [15:0] SYNC  = 16'hA5C3;

  logic        clk = 1'b0;
  logic        axis_aresetn;
  logic [31:0] s_axis_tdata;
  logic        s_axis_tvalid;
  logic        s_axis_tready;
  logic [31:0] m_axis_a_tdata;
  logic        m_axis_a_tvalid;
  logic        m_axis_a_tready;
  logic        m_axis_a_tlast;
  logic [31:0] m_axis_b_tdata;
  logic        m_axis_b_tvalid;
  logic        m_axis_b_tready;
  logic        m_axis_b_tlast;
  logic        hdr_err;
  logic        seq_err;
  logic [15:0] frame_cnt;

  int checks = 0;
  int errors = 0;
  int hdr_cnt = 0;
  int seq_cnt = 0;
  int a_sent = 0;
  int b_sent = 0;
  logic [32:0] exp_a[$];
  logic [32:0] exp_b[$];

  always #5 clk = ~clk;

  pcard_unpack #(.FIFO_DEPTH(DEPTH), .SYNC_WORD(SYNC)) dut (
    .axis_aclk       (clk),
    .axis_aresetn    (axis_aresetn),
    .s_axis_tdata    (s_axis_tdata),
    .s_axis_tvalid   (s_axis_tvalid),
    .s_axis_tready   (s_axis_tready),
    .m_axis_a_tdata  (m_axis_a_tdata),
    .m_axis_a_tvalid (m_axis_a_tvalid),
    .m_axis_a_tready (m_axis_a_tready),
    .m_axis_a_tlast  (m_axis_a_tlast),
    .m_axis_b_tdata  (m_axis_b_tdata),
    .m_axis_b_tvalid (m_axis_b_tvalid),
    .m_axis_b_tready (m_axis_b_tready),
    .m_axis_b_tlast  (m_axis_b_tlast),
    .hdr_err         (hdr_err),
    .seq_err         (seq_err),
    .frame_cnt       (frame_cnt)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Monitor: samples on the falling edge, pops the scoreboard on each handshake.
  initial begin
    forever begin
      @(negedge clk);
      if (axis_aresetn) begin
        if (m_axis_a_tvalid && m_axis_a_tready) begin
          if (exp_a.size() == 0) chk("a_unexpected", {m_axis_a_tlast, m_axis_a_tdata}, 64'h1_FFFF_FFFF_F);
          else chk("a_sample", {m_axis_a_tlast, m_axis_a_tdata}, exp_a.pop_front());
        end
        if (m_axis_b_tvalid && m_axis_b_tready) begin
          if (exp_b.size() == 0) chk("b_unexpected", {m_axis_b_tlast, m_axis_b_tdata}, 64'h1_FFFF_FFFF_F);
          else chk("b_sample", {m_axis_b_tlast, m_axis_b_tdata}, exp_b.pop_front());
        end
      end
      if (hdr_err) hdr_cnt++;
      if (seq_err) seq_cnt++;
    end
  end

  // All drive tasks start and end 1 time unit after a rising edge.
  task automatic send(input logic [31:0] w);
    int t;
    s_axis_tdata  = w;
    s_axis_tvalid = 1'b1;
    t = 0;
    while (!s_axis_tready && t < 1000) begin
      @(posedge clk); #1;
      t++;
    end
    if (t >= 1000) chk("send_timeout", 64'(t), 64'd0);
    @(posedge clk); #1;
    s_axis_tvalid = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] seq, input int len, input logic [31:0] base);
    logic [31:0] a;
    logic [31:0] b;
    logic        l;
    send({SYNC, seq, 8'(len)});
    for (int i = 0; i < len; i++) begin
      a = base + 32'(2 * i);
      b = a + 32'd1;
      l = (i == len - 1);
      exp_a.push_back({l, a});
      send(a);
      a_sent++;
      exp_b.push_back({l, b});
      send(b);
      b_sent++;
    end
  endtask

  task automatic drain(input string name);
    int t;
    t = 0;
    while ((exp_a.size() != 0 || exp_b.size() != 0) && t < 3000) begin
      @(posedge clk); #1;
      t++;
    end
    chk({name, "_drain_a"}, 64'(exp_a.size()), 64'd0);
    chk({name, "_drain_b"}, 64'(exp_b.size()), 64'd0);
  endtask

  task automatic do_reset();
    axis_aresetn = 1'b0;
    exp_a.delete();
    exp_b.delete();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_tready", 64'(s_axis_tready), 64'd0);
    chk("rst_tvalid", {m_axis_a_tvalid, m_axis_b_tvalid}, 64'd0);
    chk("rst_tlast", {m_axis_a_tlast, m_axis_b_tlast}, 64'd0);
    chk("rst_tdata", {m_axis_a_tdata, m_axis_b_tdata}, 64'd0);
    chk("rst_err", {hdr_err, seq_err}, 64'd0);
    chk("rst_frame_cnt", 64'(frame_cnt), 64'd0);
    axis_aresetn = 1'b1;
    #1;
    chk("rel_tready", 64'(s_axis_tready), 64'd1);
  endtask

  initial begin
    int h0;
    int s0;
    bit stall_seen;
    bit done;
    axis_aresetn    = 1'b0;
    s_axis_tdata    = '0;
    s_axis_tvalid   = 1'b0;
    m_axis_a_tready = 1'b1;
    m_axis_b_tready = 1'b1;
    @(posedge clk); #1;

    // Basic frame: seq 0, two pairs.
    do_reset();
    h0 = hdr_cnt; s0 = seq_cnt;
    send_frame(8'h00, 2, 32'hA0B0_0000);
    drain("t1");
    chk("t1_frame_cnt", 64'(frame_cnt), 64'd1);
    chk("t1_errs", 64'((hdr_cnt - h0) + (seq_cnt - s0)), 64'd0);

    // Hunt through junk, then a framing error in HDR, then recovery.
    do_reset();
    h0 = hdr_cnt; s0 = seq_cnt;
    repeat (3) send(32'h1234_5678);
    repeat (2) begin @(posedge clk); #1; end
    chk("t2_hunt_no_err", 64'(hdr_cnt - h0), 64'd0);
    send_frame(8'h05, 1, 32'h0000_1000);
    send(32'hDEAD_BEEF);
    repeat (2) begin @(posedge clk); #1; end
    chk("t2_hdr_err", 64'(hdr_cnt - h0), 64'd1);
    send_frame(8'h06, 1, 32'h0000_2000);
    drain("t2");
    chk("t2_frame_cnt", 64'(frame_cnt), 64'd2);
    chk("t2_seq_err", 64'(seq_cnt - s0), 64'd0);

    // Sequence wrap FE, FF, 00 legal; 02 skips 01.
    do_reset();
    h0 = hdr_cnt; s0 = seq_cnt;
    send_frame(8'hFE, 1, 32'h0000_3000);
    send_frame(8'hFF, 1, 32'h0000_3010);
    send_frame(8'h00, 1, 32'h0000_3020);
    repeat (2) begin @(posedge clk); #1; end
    chk("t3_wrap_ok", 64'(seq_cnt - s0), 64'd0);
    send_frame(8'h02, 1, 32'h0000_3030);
    drain("t3");
    chk("t3_seq_err", 64'(seq_cnt - s0), 64'd1);
    chk("t3_hdr_err", 64'(hdr_cnt - h0), 64'd0);
    chk("t3_frame_cnt", 64'(frame_cnt), 64'd4);

    // Channel B stalled: FIFO B fills after DEPTH samples, input stalls in SAMP_B.
    do_reset();
    h0 = hdr_cnt; s0 = seq_cnt;
    a_sent = 0; b_sent = 0;
    stall_seen = 1'b0;
    m_axis_b_tready = 1'b0;
    fork
      send_frame(8'h10, DEPTH + 2, 32'h0000_4000);
      begin
        for (int i = 0; i < 400 && !stall_seen; i++) begin
          @(negedge clk);
          if (s_axis_tvalid && !s_axis_tready) begin
            stall_seen = 1'b1;
            chk("t4_stall_b_sent", 64'(b_sent), 64'(DEPTH));
            chk("t4_stall_a_sent", 64'(a_sent), 64'(DEPTH + 1));
          end
        end
        chk("t4_stall_seen", 64'(stall_seen), 64'd1);
        repeat (3) @(posedge clk);
        #1;
        m_axis_b_tready = 1'b1;
      end
    join
    drain("t4");
    chk("t4_frame_cnt", 64'(frame_cnt), 64'd1);
    chk("t4_errs", 64'((hdr_cnt - h0) + (seq_cnt - s0)), 64'd0);

    // Reset mid-frame with both FIFOs holding data.
    m_axis_a_tready = 1'b0;
    m_axis_b_tready = 1'b0;
    send({SYNC, 8'h11, 8'd4});
    send(32'h0000_5000);
    send(32'h0000_5001);
    send(32'h0000_5002);
    chk("t5_pre_vld", {m_axis_a_tvalid, m_axis_b_tvalid}, 64'h3);
    chk("t5_pre_cnt", 64'(frame_cnt), 64'd1);
    axis_aresetn = 1'b0;
    #2;
    chk("t5_async_vld", {m_axis_a_tvalid, m_axis_b_tvalid}, 64'd0);
    chk("t5_async_cnt", 64'(frame_cnt), 64'd0);
    @(posedge clk); #1;
    m_axis_a_tready = 1'b1;
    m_axis_b_tready = 1'b1;
    do_reset();
    h0 = hdr_cnt; s0 = seq_cnt;
    send_frame(8'h80, 2, 32'h0000_6000);
    drain("t5");
    chk("t5_frame_cnt", 64'(frame_cnt), 64'd1);
    chk("t5_seq_err", 64'(seq_cnt - s0), 64'd0);

    // 256 back-to-back single-pair frames with random consumer ready.
    do_reset();
    h0 = hdr_cnt; s0 = seq_cnt;
    done = 1'b0;
    fork
      begin
        for (int f = 0; f < 256; f++) send_frame(8'(f), 1, 32'h7000_0000 + 32'(f << 4));
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk); #1;
          m_axis_a_tready = 1'($urandom_range(0, 1));
          m_axis_b_tready = 1'($urandom_range(0, 1));
        end
      end
    join
    m_axis_a_tready = 1'b1;
    m_axis_b_tready = 1'b1;
    drain("t6");
    chk("t6_frame_cnt", 64'(frame_cnt), 64'd256);
    chk("t6_errs", 64'((hdr_cnt - h0) + (seq_cnt - s0)), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
